// File: rtl/hist_eq_pkg.sv
// Shared constants and FSM encoding for the histogram equalizer scratch reader.
package hist_eq_pkg;

    localparam int BINS_PER_WORD = 4;
    localparam int BIN_W         = 32;
    localparam int HIST_WORDS    = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/hist_rd_fifo2.sv
// Two-entry valid/ready FIFO carrying {cdf_index, cdf_data}; push and pop may
// coincide on a full FIFO.
module hist_rd_fifo2 #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // NOTE: storage is reset as well: it is only two entries and the head is
    // visible on cdf_data, which must read zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid     = (count_q != 2'd0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/hist_scratch_reader.sv
// Reads the 256-bin histogram from scratch, streams saturating prefix-sum (CDF) words.
// Optional `HIST_CDF_MIN_EN` captures the first nonzero CDF value on cdf_min.
module hist_scratch_reader #(
    parameter int                 ADDR_W    = 17,
    parameter int                 NUM_WORDS = 64,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 BIN_W     = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [4*BIN_W-1:0]   rdata,
    output logic                 cdf_valid,
    input  logic                 cdf_ready,
    output logic [4*BIN_W-1:0]   cdf_data,
    output logic [5:0]           cdf_index,
    output logic [BIN_W-1:0]     cdf_min
);
    import hist_eq_pkg::*;

    localparam int CNT_W  = $clog2(NUM_WORDS + 1);
    localparam int FIFO_W = 6 + 4 * BIN_W;

    rd_state_e          state_q, state_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [5:0]         ret_idx_q, ret_idx_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic               inflight_q;
    logic               rd_en_c;
    logic [BIN_W-1:0]   c [BINS_PER_WORD];
    logic [4*BIN_W-1:0] cdf_word;
    logic [BIN_W-1:0]   run_sum;
    logic [1:0]         fifo_count;
    logic [2:0]         occ_c;
    logic               pop;

    function automatic logic [BIN_W-1:0] sat_add(input logic [BIN_W-1:0] a,
                                                  input logic [BIN_W-1:0] b);
        logic [BIN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[BIN_W] ? '1 : s[BIN_W-1:0];
    endfunction

    // NOTE: blocking assignments here chain the running sum through the four bins in one cycle.
    always_comb begin
        run_sum  = acc_q;
        cdf_word = '0;
        for (int k = 0; k < BINS_PER_WORD; k++) begin
            run_sum                   = sat_add(run_sum, rdata[BIN_W*k +: BIN_W]);
            c[k]                      = run_sum;
            cdf_word[BIN_W*k +: BIN_W] = run_sum;
        end
    end

    assign pop   = cdf_valid && cdf_ready;
    // Words the FIFO will hold once the current return and pop settle.
    assign occ_c = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        ret_idx_d = ret_idx_q;
        acc_d     = acc_q;
        rd_en_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_READ;
                    rd_cnt_d  = '0;
                    ret_idx_d = '0;
                    acc_d     = '0;
                end
            end
            ST_READ: begin
                if ((rd_cnt_q != CNT_W'(NUM_WORDS)) && (occ_c < 3'd2)) begin
                    rd_en_c  = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (rd_cnt_d == CNT_W'(NUM_WORDS)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (fifo_count == {1'b0, pop})) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (inflight_q) begin
            acc_d     = c[BINS_PER_WORD-1];
            ret_idx_d = ret_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rd_cnt_q   <= '0;
            ret_idx_q  <= '0;
            acc_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            ret_idx_q  <= ret_idx_d;
            acc_q      <= acc_d;
            inflight_q <= rd_en_c;
        end
    end

    assign rd_en   = rd_en_c;
    assign rd_addr = BASE_ADDR + ADDR_W'(rd_cnt_q);
    assign busy    = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);

    hist_rd_fifo2 #(.W(FIFO_W)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({ret_idx_q, cdf_word}),
        .pop       (pop),
        .valid     (cdf_valid),
        .head_data ({cdf_index, cdf_data}),
        .count     (fifo_count)
    );

`ifdef HIST_CDF_MIN_EN
    logic [BIN_W-1:0] min_q, min_d;
    logic             min_found_q, min_found_d;

    // The CDF is monotonic, so the first nonzero entry seen is the minimum nonzero one.
    always_comb begin
        min_d       = min_q;
        min_found_d = min_found_q;
        if ((state_q == ST_IDLE) && start) begin
            min_d       = '0;
            min_found_d = 1'b0;
        end else if (inflight_q) begin
            for (int k = 0; k < BINS_PER_WORD; k++) begin
                if (!min_found_d && (c[k] != '0)) begin
                    min_d       = c[k];
                    min_found_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            min_q       <= '0;
            min_found_q <= 1'b0;
        end else begin
            min_q       <= min_d;
            min_found_q <= min_found_d;
        end
    end

    assign cdf_min = min_q;
`else
    assign cdf_min = '0;
`endif

endmodule

// File: tb/tb_hist_scratch_reader.sv
// Directed bench for hist_scratch_reader: scratch memory model, stream monitor, hand-computed CDF words.
module tb_hist_scratch_reader;

    localparam int NW = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, rd_en, cdf_valid;
    logic         cdf_ready = 1'b1;
    logic [16:0]  rd_addr;
    logic [127:0] rdata = {4{32'hDEAD_BEEF}};
    logic [127:0] cdf_data;
    logic [5:0]   cdf_index;
    logic [31:0]  cdf_min;

    always #5 clock = ~clock;

    hist_scratch_reader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rdata     (rdata),
        .cdf_valid (cdf_valid),
        .cdf_ready (cdf_ready),
        .cdf_data  (cdf_data),
        .cdf_index (cdf_index),
        .cdf_min   (cdf_min)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scratch memory: data for a read issued in cycle n is presented during cycle n+1.
    logic [31:0] hist [256];
    logic        pend_en = 1'b0;
    logic [16:0] pend_addr = '0;

    always @(negedge clock) begin
        pend_en   = rd_en;
        pend_addr = rd_addr;
    end

    always @(posedge clock) begin
        int a;
        #1;
        a = int'(pend_addr);
        if (pend_en && a < NW)
            rdata = {hist[4*a+3], hist[4*a+2], hist[4*a+1], hist[4*a]};
        else
            rdata = {4{32'hDEAD_BEEF}};
    end

    // cdf_ready driver: mode 0 always ready, mode 1 alternates with one 10-cycle stall.
    int cyc = 0;
    int ready_mode = 0;
    int stall_left = 0;
    logic [127:0] got_data [$];
    int           got_idx  [$];

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        #1;
        if (ready_mode == 0) begin
            cdf_ready = 1'b1;
        end else if (got_data.size() >= 30 && stall_left > 0) begin
            cdf_ready = 1'b0;
            stall_left--;
        end else begin
            cdf_ready = (cyc % 2 == 0);
        end
    end

    // Stream monitor.
    int occ = 0, infl = 0, rd_issued = 0;
    int credit_err = 0, addr_err = 0, stable_err = 0, done_busy_err = 0;
    int done_cnt = 0, start_cyc = 0, first_rd_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
    bit           prev_hold = 1'b0;
    logic [127:0] prev_data;
    logic [5:0]   prev_idx;
    int           mon_pop;

    always @(negedge clock) begin
        if (!reset) begin
            occ       = 0;
            infl      = 0;
            prev_hold = 1'b0;
        end else begin
            mon_pop = (cdf_valid && cdf_ready) ? 1 : 0;
            if (rd_en) begin
                if (occ + infl - mon_pop >= 2) credit_err++;
                if (int'(rd_addr) != rd_issued) addr_err++;
                rd_issued++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (prev_hold && (!cdf_valid || cdf_data !== prev_data || cdf_index !== prev_idx))
                stable_err++;
            if (cdf_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (mon_pop == 1) begin
                got_data.push_back(cdf_data);
                got_idx.push_back(int'(cdf_index));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) done_busy_err++;
            end
            occ       = occ + infl - mon_pop;
            infl      = rd_en ? 1 : 0;
            prev_hold = cdf_valid && !cdf_ready;
            prev_data = cdf_data;
            prev_idx  = cdf_index;
        end
    end

    task automatic clear_mon();
        got_data.delete();
        got_idx.delete();
        rd_issued = 0; credit_err = 0; addr_err = 0; stable_err = 0; done_busy_err = 0;
        done_cnt = 0; first_rd_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
    endtask

    task automatic load_hist(input int kind);
        for (int b = 0; b < 256; b++) begin
            case (kind)
                1:       hist[b] = 32'd1;
                2:       hist[b] = (b == 0) ? 32'd65536 : 32'd0;
                3:       hist[b] = (b == 200) ? 32'd7 : 32'd0;
                default: hist[b] = (b < 2) ? 32'hFFFF_FFF0 : 32'd0;
            endcase
        end
    endtask

    function automatic logic [127:0] exp_word(input int kind, input int i);
        logic [127:0] w;
        logic [31:0]  v;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            case (kind)
                1:       v = 32'(4*i + k + 1);
                2:       v = 32'd65536;
                3:       v = (4*i + k >= 200) ? 32'd7 : 32'd0;
                default: v = (i == 0 && k == 0) ? 32'hFFFF_FFF0 : 32'hFFFF_FFFF;
            endcase
            w[32*k +: 32] = v;
        end
        return w;
    endfunction

    function automatic logic [31:0] min_exp(input logic [31:0] v);
`ifdef HIST_CDF_MIN_EN
        return v;
`else
        return (v == 32'd0) ? v : 32'd0;
`endif
    endfunction

    task automatic run_pass(input string tag, input bit timing, input bit extra);
        int n;
        clear_mon();
        @(posedge clock); #1;
        start     = 1'b1;
        start_cyc = cyc;
        check({tag, "_busy_at_start"}, busy, 0);
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        if (extra) begin
            repeat (8) @(posedge clock);
            #1 start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            @(posedge clock);
            n++;
        end
        check({tag, "_done_seen"}, (n < 1000), 1);
        repeat (3) @(posedge clock);
        if (timing) begin
            check({tag, "_rd_latency"},    first_rd_cyc - start_cyc,    1);
            check({tag, "_valid_latency"}, first_valid_cyc - start_cyc, 3);
            check({tag, "_done_latency"},  done_cyc - start_cyc,        NW + 3);
        end
    endtask

    task automatic check_pass(input string tag, input int kind, input logic [31:0] min_v);
        check({tag, "_word_count"}, got_data.size(), NW);
        for (int i = 0; i < NW && i < got_data.size(); i++) begin
            check($sformatf("%s_idx%0d", tag, i),  got_idx[i],  i);
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_word(kind, i));
        end
        check({tag, "_reads_issued"}, rd_issued, NW);
        check({tag, "_credit"},       credit_err, 0);
        check({tag, "_addr_order"},   addr_err, 0);
        check({tag, "_hold_stable"},  stable_err, 0);
        check({tag, "_busy_at_done"}, done_busy_err, 0);
        check({tag, "_done_pulses"},  done_cnt, 1);
        check({tag, "_cdf_min"},      cdf_min, min_exp(min_v));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy",      busy, 0);
        check("rst_done",      done, 0);
        check("rst_rd_en",     rd_en, 0);
        check("rst_valid",     cdf_valid, 0);
        check("rst_rd_addr",   rd_addr, 0);
        check("rst_cdf_data",  cdf_data, 0);
        check("rst_cdf_index", cdf_index, 0);
        check("rst_cdf_min",   cdf_min, 0);
        @(negedge clock) reset = 1'b1;

        load_hist(1); run_pass("s1", 1'b1, 1'b0); check_pass("s1", 1, 32'd1);
        load_hist(2); run_pass("s2", 1'b0, 1'b0); check_pass("s2", 2, 32'd65536);
        load_hist(3); run_pass("s3", 1'b0, 1'b0); check_pass("s3", 3, 32'd7);
        load_hist(5); run_pass("s5", 1'b0, 1'b0); check_pass("s5", 5, 32'hFFFF_FFF0);

        load_hist(1);
        stall_left = 10;
        ready_mode = 1;
        run_pass("s4", 1'b0, 1'b0);
        check_pass("s4", 1, 32'd1);
        ready_mode = 0;

        // Reset in the middle of a pass, then a clean rerun with a stray start while busy.
        clear_mon();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        n = 0;
        while (got_data.size() < 20 && n < 1000) begin
            @(posedge clock);
            n++;
        end
        check("s6_reached_word20", (n < 1000), 1);
        #1 reset = 1'b0;
        @(negedge clock);
        check("s6_rst_busy",    busy, 0);
        check("s6_rst_done",    done, 0);
        check("s6_rst_rd_en",   rd_en, 0);
        check("s6_rst_valid",   cdf_valid, 0);
        check("s6_rst_rd_addr", rd_addr, 0);
        check("s6_rst_data",    cdf_data, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        repeat (3) @(posedge clock);
        check("s6_no_done", done_cnt, 0);
        check("s6_idle_busy", busy, 0);
        run_pass("s6", 1'b1, 1'b1);
        check_pass("s6", 1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
